// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
package pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Encoding matches the occupancy count so the state flops can drive count directly.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

endpackage

// File: rtl/dffe_param.sv
// Parametrised enabled register with synchronous clear to RESET_VAL.
module dffe_param #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Main register holds the older entry and drives out_data; skid holds the younger.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             send;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    assign accept = in_valid & in_ready;
    assign send   = out_valid & out_ready;
    assign count  = 2'(state);

    // State and handshake flops; flags are precomputed from the next state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
        end
    end

    // Next state and register enables; flush drops occupancy but leaves data untouched.
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = BUSY;
                        main_en   = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && !send) begin
                        state_nxt = FULL;
                        skid_en   = 1'b1;
                    end else if (accept && send) begin
                        main_en   = 1'b1;
                    end else if (send) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (send) begin
                        state_nxt = BUSY;
                        main_en   = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    dffe_param #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk (clk),
        .clr (clr),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    dffe_param #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk (clk),
        .clr (clr),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench: a queue model of the stage checked every cycle against a
// 32-bit (RESET_VAL 0) and an 8-bit (RESET_VAL 0x5A) instance, plus directed literals.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic [1:0]  count_a;
    logic        in_ready_b, out_valid_b;
    logic [7:0]  out_data_b;
    logic [1:0]  count_b;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut_a (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .count     (count_a)
    );

    pipe_skid_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) dut_b (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_data   (in_data[7:0]),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .count     (count_b)
    );

    // Model: FIFO of held beats (oldest first) plus the value last at the head.
    logic [31:0] qa[$];
    logic [7:0]  qb[$];
    logic [31:0] last_a = 32'h0;
    logic [7:0]  last_b = 8'h5A;

    always @(posedge clk) begin
        bit snd, acc;
        snd = (qa.size() > 0) && out_ready;
        acc = in_valid && (qa.size() < 2);
        if (clr) begin
            qa.delete();
            qb.delete();
            last_a = 32'h0;
            last_b = 8'h5A;
        end else if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (snd) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc) begin
                qa.push_back(in_data);
                qb.push_back(in_data[7:0]);
            end
            if (qa.size() > 0) begin
                last_a = qa[0];
                last_b = qb[0];
            end
        end
        armed = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("a.out_valid", 32'(out_valid_a), 32'(qa.size() > 0));
            chk("a.in_ready",  32'(in_ready_a),  32'(qa.size() < 2));
            chk("a.count",     32'(count_a),     32'(qa.size()));
            chk("a.out_data",  out_data_a,       last_a);
            chk("b.out_valid", 32'(out_valid_b), 32'(qb.size() > 0));
            chk("b.in_ready",  32'(in_ready_b),  32'(qb.size() < 2));
            chk("b.count",     32'(count_b),     32'(qb.size()));
            chk("b.out_data",  32'(out_data_b),  32'(last_b));
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic cl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr       = cl;
        @(negedge clk);
    endtask

    initial begin
        // Reset with a live-looking input that must be ignored.
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        clr      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lit.reset.out_valid", 32'(out_valid_a), 32'd0);
        chk("lit.reset.in_ready",  32'(in_ready_a),  32'd1);
        chk("lit.reset.count",     32'(count_a),     32'd0);
        chk("lit.reset.data_a",    out_data_a,       32'h0);
        chk("lit.reset.data_b",    32'(out_data_b),  32'h5A);

        // Streaming: one beat per cycle, each visible one edge later.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
            chk("lit.stream.data",  out_data_a,      32'(i));
            chk("lit.stream.count", 32'(count_a),    32'd1);
        end
        cyc(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("lit.stream.drain", 32'(count_a), 32'd0);
        chk("lit.stream.hold",  out_data_a,   32'h8);

        // Backpressure: third beat refused while FULL, then drained in order.
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        chk("lit.bp.full_count", 32'(count_a),    32'd2);
        chk("lit.bp.full_ready", 32'(in_ready_a), 32'd0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        chk("lit.bp.head_a",     out_data_a,      32'hA);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("lit.bp.head_b",     out_data_a,      32'hB);
        chk("lit.bp.ready_back", 32'(in_ready_a), 32'd1);
        cyc(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("lit.bp.head_c",     out_data_a,      32'hC);
        chk("lit.bp.head_c_b",   32'(out_data_b), 32'h0C);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL, then a fresh beat with no stale data.
        cyc(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0,  1'b0, 1'b1, 1'b0);
        chk("lit.flush.count", 32'(count_a),     32'd0);
        chk("lit.flush.valid", 32'(out_valid_a), 32'd0);
        chk("lit.flush.ready", 32'(in_ready_a),  32'd1);
        cyc(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
        chk("lit.flush.next",  out_data_a,       32'h33);
        chk("lit.flush.cnt1",  32'(count_a),     32'd1);
        cyc(1'b0, 32'h5555, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush in BUSY with a simultaneous accept: beat dropped, main unchanged.
        cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
        chk("lit.flacc.count", 32'(count_a), 32'd0);
        chk("lit.flacc.data",  out_data_a,   32'h55);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // clr with flush and transfers pending in FULL.
        cyc(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h88, 1'b1, 1'b1, 1'b1);
        chk("lit.clr.count",  32'(count_a),     32'd0);
        chk("lit.clr.ready",  32'(in_ready_a),  32'd1);
        chk("lit.clr.data_a", out_data_a,       32'h0);
        chk("lit.clr.data_b", 32'(out_data_b),  32'h5A);

        // Mixed traffic afterwards to exercise every transition once more.
        cyc(1'b1, 32'h1234_56A1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1234_56B2, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h1234_56C3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1234_56D4, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0,         1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0,         1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
